// File: rtl/noc_vc_credit_manager_pkg.sv
// ------------------------------------------------------------------
// noc_vc_credit_manager_pkg : shared types for the VC credit manager
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package noc_vc_credit_manager_pkg;

  localparam int NOC_VC_CHANNEL    = 4;
  localparam int NOC_DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } vc_state_e;

  typedef logic [$clog2(NOC_DEFAULT_DEPTH+1)-1:0] credit_cnt_t;

  // A single-VC port still needs a one-bit VC select field.
  function automatic int vc_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/noc_vc_credit_counter.sv
// ------------------------------------------------------------------
// noc_vc_credit_counter : one VC's credit count, ownership FSM and ready flag
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module noc_vc_credit_counter
  import noc_vc_credit_manager_pkg::*;
#(
  parameter int DEPTH     = NOC_DEFAULT_DEPTH,
  parameter int ATOMIC_VC = 1
) (
  input  logic noc_clk,
  input  logic noc_rst_n,
  input  logic send_i,
  input  logic ret_i,
  input  logic sop_i,
  input  logic eop_i,
  output logic ready_o,
  output logic idle_o,
  output logic err_o
);

  localparam int             CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  vc_state_e        state_q, state_d;
  logic             ready_q, idle_q;
  logic             cnt_err, fsm_err;

  function automatic logic ready_of(input vc_state_e s, input logic [CNT_W-1:0] c);
    case (s)
      IDLE:    return (ATOMIC_VC != 0) ? (c == FULL) : (c != '0);
      BUSY:    return (c != '0);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    cnt_d   = cnt_q;
    cnt_err = 1'b0;
    if (send_i && !ret_i) begin
      if (cnt_q == '0) cnt_err = 1'b1;
      else             cnt_d   = cnt_q - 1'b1;
    end else if (ret_i && !send_i) begin
      if (cnt_q == FULL) cnt_err = 1'b1;
      else               cnt_d   = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    fsm_err = 1'b0;
    if (send_i) begin
      case (state_q)
        IDLE: begin
          if (!sop_i)               fsm_err = 1'b1;
          else if (!eop_i)          state_d = BUSY;
          else if (ATOMIC_VC != 0)  state_d = DRAIN;
        end
        BUSY: begin
          if (sop_i)                fsm_err = 1'b1;
          else if (eop_i)           state_d = (ATOMIC_VC != 0) ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (sop_i)                fsm_err = 1'b1;
        end
        default:                    state_d = IDLE;
      endcase
    end
    // A drained VC is released once every downstream slot is free again.
    if (state_q == DRAIN && cnt_d == FULL) state_d = IDLE;
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      cnt_q   <= FULL;
      state_q <= IDLE;
      ready_q <= 1'b1;
      idle_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      ready_q <= ready_of(state_d, cnt_d);
      idle_q  <= (state_d == IDLE);
    end
  end

  assign ready_o = ready_q;
  assign idle_o  = idle_q;
  assign err_o   = cnt_err | fsm_err | (send_i & ~ready_q);

endmodule

`default_nettype wire

// File: rtl/noc_vc_credit_manager.sv
// ------------------------------------------------------------------
// noc_vc_credit_manager : per-port VC credit manager driving vc_ready_o
// Optional stall statistics: NOC_CREDIT_STATS_EN.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module noc_vc_credit_manager
  import noc_vc_credit_manager_pkg::*;
#(
  parameter int CHANNELS  = NOC_VC_CHANNEL,
  parameter int DEPTH     = NOC_DEFAULT_DEPTH,
  parameter int ATOMIC_VC = 1,
  localparam int VC_W     = vc_width(CHANNELS)
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic                      flit_valid_i,
  input  logic [VC_W-1:0]           flit_vc_i,
  input  logic                      flit_sop_i,
  input  logic                      flit_eop_i,
  input  logic                      credit_valid_i,
  input  logic [VC_W-1:0]           credit_vc_i,
`ifdef NOC_CREDIT_STATS_EN
  input  logic [CHANNELS-1:0]       vc_req_i,
  input  logic                      stat_clear_i,
  output logic [CHANNELS-1:0][15:0] stall_cnt_o,
`endif
  output logic [CHANNELS-1:0]       vc_ready_o,
  output logic [CHANNELS-1:0]       vc_idle_o,
  output logic                      err_o
);

  logic                flit_ok, credit_ok;
  logic [CHANNELS-1:0] vc_err;
  logic                err_q, err_d;

  // The range check only exists when the VC field can encode unused values.
  if ((1 << VC_W) > CHANNELS) begin : g_range_chk
    assign flit_ok   = (flit_vc_i   < VC_W'(CHANNELS));
    assign credit_ok = (credit_vc_i < VC_W'(CHANNELS));
  end else begin : g_range_full
    assign flit_ok   = 1'b1;
    assign credit_ok = 1'b1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_vc
    localparam logic [VC_W-1:0] IDX = VC_W'(i);
    logic send, ret;

    assign send = flit_valid_i   && flit_ok   && (flit_vc_i   == IDX);
    assign ret  = credit_valid_i && credit_ok && (credit_vc_i == IDX);

    noc_vc_credit_counter #(
      .DEPTH     (DEPTH),
      .ATOMIC_VC (ATOMIC_VC)
    ) u_cnt (
      .noc_clk   (noc_clk),
      .noc_rst_n (noc_rst_n),
      .send_i    (send),
      .ret_i     (ret),
      .sop_i     (flit_sop_i),
      .eop_i     (flit_eop_i),
      .ready_o   (vc_ready_o[i]),
      .idle_o    (vc_idle_o[i]),
      .err_o     (vc_err[i])
    );
  end

  assign err_d = err_q | (|vc_err)
               | (flit_valid_i   & ~flit_ok)
               | (credit_valid_i & ~credit_ok);

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) err_q <= 1'b0;
    else            err_q <= err_d;
  end

  assign err_o = err_q;

`ifdef NOC_CREDIT_STATS_EN
  for (genvar i = 0; i < CHANNELS; i++) begin : g_stat
    logic [15:0] stall_q, stall_d;

    always_comb begin
      stall_d = stall_q;
      if (stat_clear_i)
        stall_d = '0;
      else if (vc_req_i[i] && !vc_ready_o[i] && stall_q != 16'hFFFF)
        stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) stall_q <= '0;
      else            stall_q <= stall_d;
    end

    assign stall_cnt_o[i] = stall_q;
  end
`else
  // No stall statistics in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_vc_credit_manager.sv
// ------------------------------------------------------------------
// tb_noc_vc_credit_manager : scoreboard bench, atomic and non-atomic instances
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_noc_vc_credit_manager;

  localparam int CH = 3;
  localparam int DP = 4;

  logic noc_clk   = 1'b0;
  logic noc_rst_n = 1'b0;
  always #5 noc_clk = ~noc_clk;

  logic       flit_valid, flit_sop, flit_eop, credit_valid;
  logic [1:0] flit_vc, credit_vc;
  logic [2:0] rdy_a, idle_a, rdy_n, idle_n;
  logic       err_a, err_n;
`ifdef NOC_CREDIT_STATS_EN
  logic [2:0]       vc_req;
  logic             stat_clear;
  logic [2:0][15:0] stall_a, stall_n;
`endif

  noc_vc_credit_manager #(.CHANNELS(CH), .DEPTH(DP), .ATOMIC_VC(1)) u_atom (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .flit_valid_i(flit_valid), .flit_vc_i(flit_vc),
    .flit_sop_i(flit_sop), .flit_eop_i(flit_eop),
    .credit_valid_i(credit_valid), .credit_vc_i(credit_vc),
`ifdef NOC_CREDIT_STATS_EN
    .vc_req_i(vc_req), .stat_clear_i(stat_clear), .stall_cnt_o(stall_a),
`endif
    .vc_ready_o(rdy_a), .vc_idle_o(idle_a), .err_o(err_a)
  );

  noc_vc_credit_manager #(.CHANNELS(CH), .DEPTH(DP), .ATOMIC_VC(0)) u_nonatom (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .flit_valid_i(flit_valid), .flit_vc_i(flit_vc),
    .flit_sop_i(flit_sop), .flit_eop_i(flit_eop),
    .credit_valid_i(credit_valid), .credit_vc_i(credit_vc),
`ifdef NOC_CREDIT_STATS_EN
    .vc_req_i(vc_req), .stat_clear_i(stat_clear), .stall_cnt_o(stall_n),
`endif
    .vc_ready_o(rdy_n), .vc_idle_o(idle_n), .err_o(err_n)
  );

  typedef struct packed {
    logic       rst;
    logic       fv;
    logic [1:0] fvc;
    logic       sop;
    logic       eop;
    logic       cv;
    logic [1:0] cvc;
  } stim_t;

  typedef struct packed {
    logic [2:0] a_rdy;
    logic [2:0] a_idle;
    logic       a_err;
    logic [2:0] n_rdy;
    logic [2:0] n_idle;
    logic       n_err;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] sq[$];
  int          vectors     = 0;
  int          miscompares = 0;

  function automatic vec_t V(input logic r, input logic fv, input logic [1:0] fvc,
                             input logic so, input logic eo, input logic cv,
                             input logic [1:0] cvc,
                             input logic [2:0] ar, input logic [2:0] ai, input logic ae,
                             input logic [2:0] nr, input logic [2:0] ni, input logic ne);
    return {r, fv, fvc, so, eo, cv, cvc, ar, ai, ae, nr, ni, ne};
  endfunction

  function automatic exp_t obs();
    return {rdy_a, idle_a, err_a, rdy_n, idle_n, err_n};
  endfunction

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic clear_inputs();
    flit_valid = 1'b0; flit_vc = 2'd0; flit_sop = 1'b0; flit_eop = 1'b0;
    credit_valid = 1'b0; credit_vc = 2'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    noc_rst_n = 1'b0;
    repeat (2) tick();
    noc_rst_n = 1'b1;
  endtask

  task automatic apply(input stim_t s);
    if (s.rst) do_reset();
    flit_valid = s.fv; flit_vc = s.fvc; flit_sop = s.sop; flit_eop = s.eop;
    credit_valid = s.cv; credit_vc = s.cvc;
  endtask

  task automatic test_reset();
    vec_t v[$];
    exp_t e;
    v.push_back(V(1, 0,0,0,0, 0,0, 3'b111,3'b111,0, 3'b111,3'b111,0));
    v.push_back(V(0, 1,0,1,0, 0,0, 3'b111,3'b110,0, 3'b111,3'b110,0));
    foreach (v[k]) begin
      apply(v[k].s); sb.push_back(v[k].e); tick();
      e = sb.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL reset step %0d: got %h expected %h", k, obs(), e);
      end
    end
    clear_inputs();
    // Mid-packet asynchronous reset, checked before any clock edge.
    #2 noc_rst_n = 1'b0;
    sb.push_back({3'b111, 3'b111, 1'b0, 3'b111, 3'b111, 1'b0});
    #1;
    e = sb.pop_front(); vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", obs(), e);
    end
    tick(); tick();
    noc_rst_n = 1'b1;
  endtask

  task automatic test_atomic_packet();
    vec_t v[$];
    exp_t e;
    v.push_back(V(0, 1,0,1,0, 0,0, 3'b111,3'b110,0, 3'b111,3'b110,0));
    v.push_back(V(0, 1,0,0,0, 0,0, 3'b111,3'b110,0, 3'b111,3'b110,0));
    v.push_back(V(0, 1,0,0,0, 0,0, 3'b111,3'b110,0, 3'b111,3'b110,0));
    v.push_back(V(0, 1,0,0,1, 0,0, 3'b110,3'b110,0, 3'b110,3'b111,0));
    v.push_back(V(0, 0,0,0,0, 1,0, 3'b110,3'b110,0, 3'b111,3'b111,0));
    v.push_back(V(0, 0,0,0,0, 1,0, 3'b110,3'b110,0, 3'b111,3'b111,0));
    v.push_back(V(0, 0,0,0,0, 1,0, 3'b110,3'b110,0, 3'b111,3'b111,0));
    v.push_back(V(0, 0,0,0,0, 1,0, 3'b111,3'b111,0, 3'b111,3'b111,0));
    foreach (v[k]) begin
      apply(v[k].s); sb.push_back(v[k].e); tick();
      e = sb.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL atomic_packet step %0d: got %h expected %h", k, obs(), e);
      end
    end
    clear_inputs();
  endtask

  task automatic test_single_flit();
    vec_t v[$];
    exp_t e;
    v.push_back(V(0, 1,1,1,1, 0,0, 3'b101,3'b101,0, 3'b111,3'b111,0));
    v.push_back(V(0, 0,0,0,0, 1,1, 3'b111,3'b111,0, 3'b111,3'b111,0));
    foreach (v[k]) begin
      apply(v[k].s); sb.push_back(v[k].e); tick();
      e = sb.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL single_flit step %0d: got %h expected %h", k, obs(), e);
      end
    end
    clear_inputs();
  endtask

  task automatic test_same_cycle();
    vec_t v[$];
    exp_t e;
    v.push_back(V(0, 1,0,1,0, 0,0, 3'b111,3'b110,0, 3'b111,3'b110,0));
    v.push_back(V(0, 1,0,0,0, 0,0, 3'b111,3'b110,0, 3'b111,3'b110,0));
    v.push_back(V(0, 1,0,0,0, 1,0, 3'b111,3'b110,0, 3'b111,3'b110,0));
    v.push_back(V(0, 1,0,0,1, 1,0, 3'b110,3'b110,0, 3'b111,3'b111,0));
    v.push_back(V(0, 0,0,0,0, 1,0, 3'b110,3'b110,0, 3'b111,3'b111,0));
    v.push_back(V(0, 0,0,0,0, 1,0, 3'b111,3'b111,0, 3'b111,3'b111,0));
    foreach (v[k]) begin
      apply(v[k].s); sb.push_back(v[k].e); tick();
      e = sb.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL same_cycle step %0d: got %h expected %h", k, obs(), e);
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    exp_t e;
    v.push_back(V(0, 1,2,1,0, 0,0, 3'b111,3'b011,0, 3'b111,3'b011,0));
    v.push_back(V(0, 1,1,1,0, 0,0, 3'b111,3'b001,0, 3'b111,3'b001,0));
    v.push_back(V(0, 1,2,0,1, 1,1, 3'b011,3'b001,0, 3'b111,3'b101,0));
    v.push_back(V(0, 1,1,0,1, 1,2, 3'b001,3'b001,0, 3'b111,3'b111,0));
    v.push_back(V(0, 0,0,0,0, 1,1, 3'b011,3'b011,0, 3'b111,3'b111,0));
    v.push_back(V(0, 0,0,0,0, 1,2, 3'b111,3'b111,0, 3'b111,3'b111,0));
    foreach (v[k]) begin
      apply(v[k].s); sb.push_back(v[k].e); tick();
      e = sb.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL back_to_back step %0d: got %h expected %h", k, obs(), e);
      end
    end
    clear_inputs();
  endtask

  task automatic test_errors();
    vec_t v[$];
    exp_t e;
    v.push_back(V(1, 0,0,0,0, 1,1, 3'b111,3'b111,1, 3'b111,3'b111,1));
    v.push_back(V(0, 0,0,0,0, 0,0, 3'b111,3'b111,1, 3'b111,3'b111,1));
    v.push_back(V(1, 1,2,0,0, 0,0, 3'b011,3'b111,1, 3'b111,3'b111,1));
    v.push_back(V(0, 0,0,0,0, 1,2, 3'b111,3'b111,1, 3'b111,3'b111,1));
    v.push_back(V(1, 1,3,1,0, 0,0, 3'b111,3'b111,1, 3'b111,3'b111,1));
    v.push_back(V(1, 0,0,0,0, 1,3, 3'b111,3'b111,1, 3'b111,3'b111,1));
    v.push_back(V(1, 1,0,1,0, 0,0, 3'b111,3'b110,0, 3'b111,3'b110,0));
    v.push_back(V(0, 1,0,1,0, 0,0, 3'b111,3'b110,1, 3'b111,3'b110,1));
    foreach (v[k]) begin
      apply(v[k].s); sb.push_back(v[k].e); tick();
      e = sb.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL errors step %0d: got %h expected %h", k, obs(), e);
      end
    end
    clear_inputs();
  endtask

  task automatic test_underflow();
    vec_t v[$];
    exp_t e;
    v.push_back(V(1, 1,0,1,0, 0,0, 3'b111,3'b110,0, 3'b111,3'b110,0));
    v.push_back(V(0, 1,0,0,0, 0,0, 3'b111,3'b110,0, 3'b111,3'b110,0));
    v.push_back(V(0, 1,0,0,0, 0,0, 3'b111,3'b110,0, 3'b111,3'b110,0));
    v.push_back(V(0, 1,0,0,0, 0,0, 3'b110,3'b110,0, 3'b110,3'b110,0));
    v.push_back(V(0, 1,0,0,0, 0,0, 3'b110,3'b110,1, 3'b110,3'b110,1));
    v.push_back(V(0, 0,0,0,0, 1,0, 3'b111,3'b110,1, 3'b111,3'b110,1));
    foreach (v[k]) begin
      apply(v[k].s); sb.push_back(v[k].e); tick();
      e = sb.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL underflow step %0d: got %h expected %h", k, obs(), e);
      end
    end
    clear_inputs();
  endtask

`ifdef NOC_CREDIT_STATS_EN
  task automatic test_stats();
    logic [15:0] e;
    do_reset();
    apply(V(0, 1,0,1,1, 0,0, 0,0,0, 0,0,0).s);
    tick();
    clear_inputs();
    vc_req = 3'b001;
    repeat (10) tick();
    vc_req = 3'b000;
    sq.push_back(16'd10);
    sq.push_back(16'd0);
    e = sq.pop_front(); vectors++;
    if (stall_a[0] !== e) begin
      miscompares++;
      $display("FAIL stall_drain: got %0d expected %0d", stall_a[0], e);
    end
    e = sq.pop_front(); vectors++;
    if (stall_n[0] !== e) begin
      miscompares++;
      $display("FAIL stall_ready_vc: got %0d expected %0d", stall_n[0], e);
    end
    stat_clear = 1'b1;
    sq.push_back(16'd0);
    tick();
    stat_clear = 1'b0;
    e = sq.pop_front(); vectors++;
    if (stall_a[0] !== e) begin
      miscompares++;
      $display("FAIL stall_clear: got %0d expected %0d", stall_a[0], e);
    end
  endtask
`endif

  initial begin
    clear_inputs();
`ifdef NOC_CREDIT_STATS_EN
    vc_req     = 3'b000;
    stat_clear = 1'b0;
`endif
    test_reset();
    test_atomic_packet();
    test_single_flit();
    test_same_cycle();
    test_back_to_back();
    test_errors();
    test_underflow();
`ifdef NOC_CREDIT_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
